// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the approximate multiplier error sweeper.
// Holds the sweep FSM state enum, default sizes and the error-distance width.
package approx_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int PW        = 2 * DEF_WIDTH;
    localparam int NPAIRS    = 1 << PW;

    // |a - b| of two w-bit products always fits back into 2*w bits.
    function automatic int ed_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/approx_mul_err_sweeper_err_dist_unit.sv
// Combinational absolute difference of two unsigned W-bit values.
// Ports: x, y in; ed = |y - x| out; nz = (ed != 0) out.
module err_dist_unit
    import approx_mul_pkg::*;
#(
    parameter int W = PW
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] ed,
    output logic         nz
);

    logic [W:0] diff;
    logic [W:0] mag;

    always_comb begin
        diff = {1'b0, y} - {1'b0, x};
        // Negative difference: two's complement back to a magnitude.
        mag  = diff[W] ? ((~diff) + (W+1)'(1)) : diff;
        ed   = mag[W-1:0];
        nz   = |mag;
    end

endmodule

// File: rtl/approx_mul_err_sweeper.sv
// Sweeps every operand pair through an external multiplier and accumulates
// error count, sum and max of |y_in - a*b|. Ports: clk, rst, start,
// a_out/b_out operands, y_in product, busy/done status, err_count/sum_ed/max_ed.
module approx_mul_err_sweeper
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int Y_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [2*WIDTH-1:0]   y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     err_count,
    output logic [4*WIDTH-1:0]   sum_ed,
    output logic [2*WIDTH-1:0]   max_ed
);

    localparam int YW = 2 * WIDTH;
    localparam int EW = ed_width(WIDTH);
    localparam int CW = $clog2(Y_LAT + 2);

    state_t          state;
    state_t          state_nxt;
    logic [YW-1:0]   idx;
    logic [CW-1:0]   dcnt;
    logic            last_pair;
    logic            drain_end;
    logic            launch;

    logic            pv;
    logic [YW-1:0]   exact;
    logic            v_al;
    logic [YW-1:0]   ex_al;

    logic            cap_v;
    logic [YW-1:0]   y_reg;
    logic [YW-1:0]   ex_reg;
    logic [EW-1:0]   ed;
    logic            ed_nz;

    assign last_pair = (idx == '1);
    assign drain_end = (dcnt == CW'(Y_LAT));
    assign launch    = (state != SWEEP) && (state_nxt == SWEEP);

    assign a_out = idx[YW-1:WIDTH];
    assign b_out = idx[WIDTH-1:0];
    assign busy  = (state == SWEEP) || (state == DRAIN);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start)     state_nxt = SWEEP;
            SWEEP: if (last_pair) state_nxt = DRAIN;
            DRAIN: if (drain_end) state_nxt = DONE;
            DONE:  if (start)     state_nxt = SWEEP;
            default:              state_nxt = IDLE;
        endcase
    end

    // idx never wraps: it parks on the last pair through DRAIN and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            dcnt <= '0;
        end else begin
            if (launch)
                idx <= '0;
            else if (state == SWEEP && !last_pair)
                idx <= idx + YW'(1);
            if (state != DRAIN)
                dcnt <= '0;
            else if (!drain_end)
                dcnt <= dcnt + CW'(1);
        end
    end

    assign pv    = (state == SWEEP);
    assign exact = {{WIDTH{1'b0}}, a_out} * {{WIDTH{1'b0}}, b_out};

    // Delay valid and exact product so they line up with y_in.
    if (Y_LAT == 0) begin : g_nolat
        assign v_al  = pv;
        assign ex_al = exact;
    end else begin : g_lat
        logic [Y_LAT-1:0] v_dl;
        logic [YW-1:0]    ex_dl [Y_LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_dl <= '0;
            end else begin
                v_dl[0] <= pv;
                for (int i = 1; i < Y_LAT; i++)
                    v_dl[i] <= v_dl[i-1];
            end
        end

        always_ff @(posedge clk) begin
            ex_dl[0] <= exact;
            for (int i = 1; i < Y_LAT; i++)
                ex_dl[i] <= ex_dl[i-1];
        end

        assign v_al  = v_dl[Y_LAT-1];
        assign ex_al = ex_dl[Y_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_v  <= 1'b0;
            y_reg  <= '0;
            ex_reg <= '0;
        end else begin
            cap_v <= v_al;
            if (v_al) begin
                y_reg  <= y_in;
                ex_reg <= ex_al;
            end
        end
    end

    err_dist_unit #(
        .W (EW)
    ) u_ed (
        .x  (ex_reg),
        .y  (y_reg),
        .ed (ed),
        .nz (ed_nz)
    );

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
        end else if (cap_v) begin
            err_count <= err_count + {{YW{1'b0}}, ed_nz};
            sum_ed    <= sum_ed + {{(4*WIDTH-EW){1'b0}}, ed};
            if (ed > max_ed)
                max_ed <= ed;
        end
    end

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
// Self-checking bench: two sweepers (Y_LAT 0 and 2) at WIDTH=4 driving
// behavioural multiplier models, checked against a full-sweep reference.
module tb_approx_mul_err_sweeper;

    localparam int W  = 4;
    localparam int NP = 1 << (2 * W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start2 = 1'b0;

    logic [W-1:0]   a0, b0, a2, b2;
    logic [2*W-1:0] y0, y2, y2_p1, y2_p2;
    logic           busy0, done0, busy2, done2;
    logic [2*W:0]   cnt0, cnt2;
    logic [4*W-1:0] sum0, sum2;
    logic [2*W-1:0] max0, max2;

    int mode0 = 0;
    int mode2 = 0;
    logic [7:0] rtab [NP];

    int nchk  = 0;
    int nfail = 0;
    int sel   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] model_y(input int m, input int a, input int b);
        int p;
        p = a * b;
        case (m)
            1:       return 8'(p ^ 1);
            2:       return (a == 15 && b == 15) ? 8'd0 : 8'(p);
            3:       return (a == 0 && b == 1) ? 8'd5 : 8'(p);
            4:       return rtab[a*16+b];
            default: return 8'(p);
        endcase
    endfunction

    assign y0 = model_y(mode0, int'(a0), int'(b0));

    always @(posedge clk) begin
        y2_p1 <= model_y(mode2, int'(a2), int'(b2));
        y2_p2 <= y2_p1;
    end
    assign y2 = y2_p2;

    approx_mul_err_sweeper #(.WIDTH(W), .Y_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start0),
        .a_out(a0), .b_out(b0), .y_in(y0),
        .busy(busy0), .done(done0),
        .err_count(cnt0), .sum_ed(sum0), .max_ed(max0)
    );

    approx_mul_err_sweeper #(.WIDTH(W), .Y_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start2),
        .a_out(a2), .b_out(b2), .y_in(y2),
        .busy(busy2), .done(done2),
        .err_count(cnt2), .sum_ed(sum2), .max_ed(max2)
    );

    logic [W-1:0]   a_s, b_s;
    logic           busy_s, done_s;
    logic [2*W:0]   cnt_s;
    logic [4*W-1:0] sum_s;
    logic [2*W-1:0] max_s;

    assign a_s    = sel ? a2 : a0;
    assign b_s    = sel ? b2 : b0;
    assign busy_s = sel ? busy2 : busy0;
    assign done_s = sel ? done2 : done0;
    assign cnt_s  = sel ? cnt2 : cnt0;
    assign sum_s  = sel ? sum2 : sum0;
    assign max_s  = sel ? max2 : max0;

    task automatic calc_ref(input int m, output int ec, output int se, output int me);
        int d;
        ec = 0; se = 0; me = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                d = int'(model_y(m, a, b)) - a * b;
                if (d < 0) d = -d;
                if (d != 0) ec++;
                se += d;
                if (d > me) me = d;
            end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s != 0) start2 = v;
        else        start0 = v;
    endtask

    // One full sweep; p1/p2 are cycles at which a stray start is pulsed.
    task automatic sweep(input int s, input int m, input int p1, input int p2,
                         output int lat, output int seq_bad);
        int n;
        int e;
        sel = s;
        if (s != 0) mode2 = m;
        else        mode0 = m;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        n = 0;
        lat = -1;
        seq_bad = 0;
        if ({a_s, b_s} !== 8'd0 || busy_s !== 1'b1) seq_bad++;
        while (n < 2000 && lat < 0) begin
            if (n == p1 || n == p2) set_start(s, 1'b1);
            @(posedge clk);
            #1;
            set_start(s, 1'b0);
            n++;
            e = (n < NP) ? n : NP - 1;
            if (int'({a_s, b_s}) != e) seq_bad++;
            if (done_s === 1'b1) lat = n;
        end
    endtask

    task automatic check_results(input string nm, input int m);
        int ec, se, me;
        calc_ref(m, ec, se, me);
        nchk++;
        if (int'(cnt_s) !== ec) begin
            nfail++;
            $display("FAIL %s err_count got %0d want %0d", nm, cnt_s, ec);
        end
        nchk++;
        if (int'(sum_s) !== se) begin
            nfail++;
            $display("FAIL %s sum_ed got %0d want %0d", nm, sum_s, se);
        end
        nchk++;
        if (int'(max_s) !== me) begin
            nfail++;
            $display("FAIL %s max_ed got %0d want %0d", nm, max_s, me);
        end
        nchk++;
        if (busy_s !== 1'b0 || done_s !== 1'b1) begin
            nfail++;
            $display("FAIL %s status busy=%b done=%b want 0/1", nm, busy_s, done_s);
        end
    endtask

    task automatic check_lat(input string nm, input int lat, input int want, input int bad);
        nchk++;
        if (lat !== want) begin
            nfail++;
            $display("FAIL %s latency got %0d want %0d", nm, lat, want);
        end
        nchk++;
        if (bad !== 0) begin
            nfail++;
            $display("FAIL %s operand sequence errors got %0d want 0", nm, bad);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NP; i++) begin
            if ($urandom_range(3) == 0) rtab[i] = 8'($urandom_range(255));
            else                        rtab[i] = 8'((i / 16) * (i % 16));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            nchk++;
            if ({a_s, b_s, busy_s, done_s} !== 10'd0) begin
                nfail++;
                $display("FAIL reset_ctl dut%0d got a=%0d b=%0d busy=%b done=%b want 0",
                         s, a_s, b_s, busy_s, done_s);
            end
            nchk++;
            if (cnt_s !== '0 || sum_s !== '0 || max_s !== '0) begin
                nfail++;
                $display("FAIL reset_acc dut%0d got %0d/%0d/%0d want 0/0/0",
                         s, cnt_s, sum_s, max_s);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exact();
        int lat, bad;
        sweep(0, 0, -1, -1, lat, bad);
        check_lat("exact", lat, NP + 1, bad);
        check_results("exact", 0);
    endtask

    task automatic test_xor1();
        int lat, bad;
        sweep(0, 1, -1, -1, lat, bad);
        check_lat("xor1", lat, NP + 1, bad);
        check_results("xor1", 1);
    endtask

    task automatic test_last_pair();
        int lat, bad;
        sweep(0, 2, -1, -1, lat, bad);
        check_lat("last_pair", lat, NP + 1, bad);
        check_results("last_pair", 2);
    endtask

    task automatic test_latency2();
        int lat, bad;
        sweep(1, 3, -1, -1, lat, bad);
        check_lat("lat2", lat, NP + 3, bad);
        check_results("lat2", 3);
    endtask

    task automatic test_random();
        int lat, bad;
        for (int it = 0; it < 3; it++) begin
            fill_random();
            sweep(0, 4, -1, -1, lat, bad);
            check_lat("rand_l0", lat, NP + 1, bad);
            check_results("rand_l0", 4);
            sweep(1, 4, -1, -1, lat, bad);
            check_lat("rand_l2", lat, NP + 3, bad);
            check_results("rand_l2", 4);
        end
    endtask

    task automatic test_reset_mid();
        int n, lat, bad;
        fill_random();
        sel = 0;
        mode0 = 4;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        while (n < 400 && {a0, b0} != 8'd100) begin
            @(posedge clk);
            #1;
            n++;
        end
        nchk++;
        if ({a0, b0} != 8'd100) begin
            nfail++;
            $display("FAIL rst_mid_reach idx got %0d want 100", {a0, b0});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        nchk++;
        if ({a0, b0, busy0, done0} !== 10'd0 || cnt0 !== '0 || sum0 !== '0 || max0 !== '0) begin
            nfail++;
            $display("FAIL rst_mid got a=%0d b=%0d busy=%b done=%b acc=%0d/%0d/%0d want all 0",
                     a0, b0, busy0, done0, cnt0, sum0, max0);
        end
        @(negedge clk);
        rst = 1'b0;
        sweep(0, 4, -1, -1, lat, bad);
        check_lat("rst_resweep", lat, NP + 1, bad);
        check_results("rst_resweep", 4);
    endtask

    task automatic test_back_to_back();
        int lat, bad;
        // Stray starts mid-sweep and during DRAIN must not restart.
        sweep(1, 1, 50, NP + 1, lat, bad);
        check_lat("ignore_start", lat, NP + 3, bad);
        check_results("ignore_start", 1);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        nchk++;
        if (cnt2 !== '0 || sum2 !== '0 || max2 !== '0 || done2 !== 1'b0 ||
            busy2 !== 1'b1 || a2 !== '0 || b2 !== '0) begin
            nfail++;
            $display("FAIL restart got acc=%0d/%0d/%0d done=%b busy=%b a=%0d b=%0d want 0/0/0 0 1 0 0",
                     cnt2, sum2, max2, done2, busy2, a2, b2);
        end
        for (int n = 0; n < 2000 && done2 !== 1'b1; n++) begin
            @(posedge clk);
            #1;
        end
        sel = 1;
        #0;
        check_results("restart_sweep", 1);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_xor1();
        test_last_pair();
        test_latency2();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
